// File: rtl/mic_level_meter_pkg.sv
// mic_level_meter_pkg
//   Constants and types shared by the mic level meter and the code that uses
//   its outputs (for example the OLED visualiser). The visualiser sizes its
//   level input from LEVEL_W and selects its loud image with LOUD_THRESH.
package mic_level_meter_pkg;

  localparam int MIC_W          = 12;     // raw PMOD mic sample width
  localparam int AMP_W          = 11;     // amplitude width (saturates at 2047)
  localparam int LEVEL_W        = 5;      // audio level width
  localparam int MAX_LEVEL      = 16;     // audio level ceiling
  localparam int LOUD_THRESH    = 10;     // level at or above this is "loud"
  localparam int MIDPOINT       = 2048;   // mic DC offset (silence code)
  localparam int SAMPLE_RATE_HZ = 20000;  // sample_en strobe rate
  localparam int CNT_W          = 16;     // window counter width (WINDOW <= 65535)

  typedef enum logic {
    ACCUM  = 1'b0,
    UPDATE = 1'b1
  } meter_state_t;

endpackage

// File: rtl/mic_peak_window.sv
// mic_peak_window
//   Converts each strobed mic sample into an amplitude around MIDPOINT and
//   keeps a running max over a window of WINDOW samples.
//   Ports:
//     clk       - system clock, rising edge
//     reset     - synchronous, active-high
//     sample_en - one-cycle sample strobe; mic_in is valid in that cycle
//     mic_in    - raw offset-binary mic sample
//     restart   - high during the meter's UPDATE cycle; starts a new window
//     win_done  - this strobe completes the window (combinational)
//     acc       - running peak; holds the finished window's peak while
//                 restart is high
module mic_peak_window
  import mic_level_meter_pkg::*;
#(
  parameter int WINDOW   = 4000,
  parameter int MIDPOINT = mic_level_meter_pkg::MIDPOINT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_en,
  input  logic [MIC_W-1:0] mic_in,
  input  logic             restart,
  output logic             win_done,
  output logic [AMP_W-1:0] acc
);

  localparam logic [MIC_W-1:0] MID  = MIC_W'(MIDPOINT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WINDOW - 1);

  logic [MIC_W-1:0] diff;
  logic [AMP_W-1:0] amp;
  logic [CNT_W-1:0] count;

  // |mic_in - MID|; the only value that overflows 11 bits is mic_in=0
  // (2048), which clamps to 2047.
  always_comb begin
    diff = (mic_in >= MID) ? (mic_in - MID) : (MID - mic_in);
    amp  = diff[MIC_W-1] ? {AMP_W{1'b1}} : diff[AMP_W-1:0];
  end

  // A strobe during restart belongs to the next window, never this one.
  assign win_done = sample_en && !restart && (count == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      acc   <= '0;
      count <= '0;
    end else if (restart) begin
      // Fresh window: the old peak is not carried over.
      acc   <= sample_en ? amp : '0;
      count <= sample_en ? CNT_W'(1) : '0;
    end else if (sample_en) begin
      if (amp > acc) acc <= amp;
      count <= win_done ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mic_level_meter.sv
// mic_level_meter
//   Turns raw mic samples into a per-window peak amplitude and a 5-bit volume
//   level. The level rises at once when the new window is louder and decays
//   by one step per window otherwise.
//   Ports:
//     basys_clock - 100 MHz system clock, rising edge
//     reset       - synchronous, active-high
//     sample_en   - one-cycle 20 kHz sample strobe
//     MIC_IN      - raw 12-bit offset-binary mic sample
//     audio_level - smoothed level, 0..MAX_LEVEL
//     peak        - last completed window's peak amplitude
//     loud        - audio_level >= LOUD_THRESH
//     level_valid - one-cycle pulse when audio_level/peak/loud update
module mic_level_meter
  import mic_level_meter_pkg::*;
#(
  parameter int WINDOW      = 4000,
  parameter int MIDPOINT    = mic_level_meter_pkg::MIDPOINT,
  parameter int LEVEL_SHIFT = 7,
  parameter int MAX_LEVEL   = mic_level_meter_pkg::MAX_LEVEL,
  parameter int LOUD_THRESH = mic_level_meter_pkg::LOUD_THRESH
) (
  input  logic               basys_clock,
  input  logic               reset,
  input  logic               sample_en,
  input  logic [MIC_W-1:0]   MIC_IN,
  output logic [LEVEL_W-1:0] audio_level,
  output logic [AMP_W-1:0]   peak,
  output logic               loud,
  output logic               level_valid
);

  localparam logic [AMP_W-1:0]   MAX_AMP = AMP_W'(MAX_LEVEL);
  localparam logic [LEVEL_W-1:0] MAX_LV  = LEVEL_W'(MAX_LEVEL);
  localparam logic [LEVEL_W-1:0] LOUD_LV = LEVEL_W'(LOUD_THRESH);

  meter_state_t       state, state_nxt;
  logic               win_done;
  logic [AMP_W-1:0]   acc;
  logic [AMP_W-1:0]   shifted;
  logic [LEVEL_W-1:0] raw_level;
  logic [LEVEL_W-1:0] new_level;

  mic_peak_window #(
    .WINDOW   (WINDOW),
    .MIDPOINT (MIDPOINT)
  ) u_peak (
    .clk       (basys_clock),
    .reset     (reset),
    .sample_en (sample_en),
    .mic_in    (MIC_IN),
    .restart   (state == UPDATE),
    .win_done  (win_done),
    .acc       (acc)
  );

  // Level from the finished window: instant attack, single-step decay.
  always_comb begin
    shifted   = acc >> LEVEL_SHIFT;
    raw_level = (shifted > MAX_AMP) ? MAX_LV : shifted[LEVEL_W-1:0];
    new_level = (raw_level >= audio_level) ? raw_level
                                           : audio_level - LEVEL_W'(1);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (win_done) state_nxt = UPDATE;
      UPDATE:  state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge basys_clock) begin
    if (reset) begin
      state       <= ACCUM;
      audio_level <= '0;
      peak        <= '0;
      loud        <= 1'b0;
      level_valid <= 1'b0;
    end else begin
      state       <= state_nxt;
      level_valid <= 1'b0;
      if (state == UPDATE) begin
        // loud derives from new_level so it always matches audio_level.
        audio_level <= new_level;
        peak        <= acc;
        loud        <= (new_level >= LOUD_LV);
        level_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mic_level_meter.sv
module tb_mic_level_meter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sample_en = 1'b0;
  logic [11:0] mic = 12'd2048;

  logic [4:0]  lvl, lvl6;
  logic [10:0] pk, pk6;
  logic        loud, loud6, lv, lv6;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mic_level_meter #(.WINDOW(4)) dut (
    .basys_clock(clk), .reset(reset), .sample_en(sample_en), .MIC_IN(mic),
    .audio_level(lvl), .peak(pk), .loud(loud), .level_valid(lv)
  );

  // Same input stream, finer shift: exercises the MAX_LEVEL clamp.
  mic_level_meter #(.WINDOW(4), .LEVEL_SHIFT(6)) dut6 (
    .basys_clock(clk), .reset(reset), .sample_en(sample_en), .MIC_IN(mic),
    .audio_level(lvl6), .peak(pk6), .loud(loud6), .level_valid(lv6)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle strobe; returns 1ns after the capturing edge.
  task automatic strobe(input logic [11:0] v);
    sample_en = 1'b1;
    mic = v;
    tick();
    sample_en = 1'b0;
  endtask

  // Four gapped strobes; returns in the cycle where level_valid is high.
  task automatic run_window(input logic [11:0] a, b, c, d);
    strobe(a); tick();
    strobe(b); tick();
    strobe(c); tick();
    strobe(d);
    tick();
  endtask

  task automatic test_reset();
    bit seen;
    reset = 1'b1;
    sample_en = 1'b1;
    mic = 12'd0;
    repeat (3) tick();
    sample_en = 1'b0;
    checks++; if (lvl !== 5'd0)  begin errors++; $display("FAIL rst_level got=%0d exp=0", lvl); end
    checks++; if (pk !== 11'd0)  begin errors++; $display("FAIL rst_peak got=%0d exp=0", pk); end
    checks++; if (loud !== 1'b0) begin errors++; $display("FAIL rst_loud got=%0b exp=0", loud); end
    checks++; if (lv !== 1'b0)   begin errors++; $display("FAIL rst_valid got=%0b exp=0", lv); end
    reset = 1'b0;
    seen = 1'b0;
    repeat (100) begin
      tick();
      if (lv !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL idle_valid_pulsed got=1 exp=0"); end
    checks++; if (lvl !== 5'd0 || pk !== 11'd0 || loud !== 1'b0)
      begin errors++; $display("FAIL idle_outputs got=%0d/%0d/%0b exp=0/0/0", lvl, pk, loud); end
  endtask

  task automatic test_basic();
    strobe(12'd2048); tick();
    strobe(12'd2300); tick();
    strobe(12'd3348); tick();
    strobe(12'd2100);
    // UPDATE cycle: nothing visible yet.
    checks++; if (lv !== 1'b0)   begin errors++; $display("FAIL basic_valid_early got=%0b exp=0", lv); end
    checks++; if (lvl !== 5'd0)  begin errors++; $display("FAIL basic_level_early got=%0d exp=0", lvl); end
    tick();
    checks++; if (lv !== 1'b1)     begin errors++; $display("FAIL basic_valid got=%0b exp=1", lv); end
    checks++; if (pk !== 11'd1300) begin errors++; $display("FAIL basic_peak got=%0d exp=1300", pk); end
    checks++; if (lvl !== 5'd10)   begin errors++; $display("FAIL basic_level got=%0d exp=10", lvl); end
    checks++; if (loud !== 1'b1)   begin errors++; $display("FAIL basic_loud got=%0b exp=1", loud); end
    tick();
    checks++; if (lv !== 1'b0)   begin errors++; $display("FAIL basic_valid_width got=%0b exp=0", lv); end
    checks++; if (lvl !== 5'd10 || pk !== 11'd1300)
      begin errors++; $display("FAIL basic_hold got=%0d/%0d exp=10/1300", lvl, pk); end
  endtask

  task automatic test_decay();
    run_window(12'd2048, 12'd2300, 12'd3348, 12'd2100);
    checks++; if (lvl !== 5'd10) begin errors++; $display("FAIL decay_loud_level got=%0d exp=10", lvl); end
    tick();
    run_window(12'd2048, 12'd2048, 12'd2048, 12'd2048);
    checks++; if (lvl !== 5'd9)  begin errors++; $display("FAIL decay_level_9 got=%0d exp=9", lvl); end
    checks++; if (loud !== 1'b0) begin errors++; $display("FAIL decay_loud got=%0b exp=0", loud); end
    checks++; if (pk !== 11'd0)  begin errors++; $display("FAIL decay_peak got=%0d exp=0", pk); end
    for (int i = 0; i < 5; i++) begin
      tick();
      run_window(12'd2048, 12'd2048, 12'd2048, 12'd2048);
      checks++;
      if (lvl !== 5'(8 - i) || lv !== 1'b1)
        begin errors++; $display("FAIL decay_step%0d got=%0d valid=%0b exp=%0d", i, lvl, lv, 8 - i); end
    end
    tick();
  endtask

  task automatic test_saturate();
    run_window(12'd0, 12'd4095, 12'd2048, 12'd2048);
    checks++; if (pk !== 11'd2047) begin errors++; $display("FAIL sat_peak got=%0d exp=2047", pk); end
    checks++; if (lvl !== 5'd15)   begin errors++; $display("FAIL sat_level got=%0d exp=15", lvl); end
    checks++; if (loud !== 1'b1)   begin errors++; $display("FAIL sat_loud got=%0b exp=1", loud); end
    checks++; if (lvl6 !== 5'd16)  begin errors++; $display("FAIL sat_level_shift6 got=%0d exp=16", lvl6); end
    checks++; if (pk6 !== 11'd2047 || lv6 !== 1'b1)
      begin errors++; $display("FAIL sat_peak_shift6 got=%0d valid=%0b exp=2047", pk6, lv6); end
    tick();
    // amp of 0 alone must also saturate to 2047.
    run_window(12'd0, 12'd2048, 12'd2048, 12'd2048);
    checks++; if (pk !== 11'd2047) begin errors++; $display("FAIL sat_zero_peak got=%0d exp=2047", pk); end
    tick();
  endtask

  task automatic test_back_to_back();
    // Four strobes in consecutive cycles, then a fifth during UPDATE.
    sample_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mic = 12'd2048;
      tick();
    end
    mic = 12'd4000;
    tick();
    sample_en = 1'b0;
    checks++; if (lv !== 1'b1)   begin errors++; $display("FAIL b2b_valid got=%0b exp=1", lv); end
    checks++; if (pk !== 11'd0)  begin errors++; $display("FAIL b2b_peak_excl got=%0d exp=0", pk); end
    checks++; if (lvl !== 5'd14) begin errors++; $display("FAIL b2b_level got=%0d exp=14", lvl); end
    tick();
    strobe(12'd2048); tick();
    strobe(12'd2048); tick();
    strobe(12'd2048);
    tick();
    checks++; if (lv !== 1'b1)      begin errors++; $display("FAIL b2b_next_valid got=%0b exp=1", lv); end
    checks++; if (pk !== 11'd1952)  begin errors++; $display("FAIL b2b_next_peak got=%0d exp=1952", pk); end
    checks++; if (lvl !== 5'd15)    begin errors++; $display("FAIL b2b_next_level got=%0d exp=15", lvl); end
    tick();
  endtask

  task automatic test_reset_mid();
    strobe(12'd3348); tick();
    strobe(12'd3348); tick();
    reset = 1'b1;
    sample_en = 1'b1;
    mic = 12'd4095;
    tick();
    reset = 1'b0;
    sample_en = 1'b0;
    checks++; if (lvl !== 5'd0 || loud !== 1'b0 || pk !== 11'd0)
      begin errors++; $display("FAIL midrst_outputs got=%0d/%0b/%0d exp=0/0/0", lvl, loud, pk); end
    for (int k = 0; k < 3; k++) begin
      strobe(12'd2048);
      tick();
      checks++; if (lv !== 1'b0) begin errors++; $display("FAIL midrst_early_valid%0d got=1 exp=0", k); end
      tick();
      checks++; if (lv !== 1'b0) begin errors++; $display("FAIL midrst_early_valid%0db got=1 exp=0", k); end
    end
    strobe(12'd2048);
    checks++; if (lv !== 1'b0) begin errors++; $display("FAIL midrst_update_valid got=1 exp=0"); end
    tick();
    checks++; if (lv !== 1'b1) begin errors++; $display("FAIL midrst_valid got=%0b exp=1", lv); end
    checks++; if (lvl !== 5'd0 || loud !== 1'b0 || pk !== 11'd0)
      begin errors++; $display("FAIL midrst_final got=%0d/%0b/%0d exp=0/0/0", lvl, loud, pk); end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_decay();
    test_saturate();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
